// File: rtl/pole_adapt_if.sv
// Start/result handshake between the ADPCM adder stage and the pole-coefficient
// adaptation engine.
interface pole_adapt_if #(
   parameter int CW = 5
);
   logic          start;
   logic [CW-1:0] chan;
   logic          PK0;
   logic          SIGPK;
   logic          TR;
   logic          busy;
   logic          done;
   logic [15:0]   A1;
   logic [15:0]   A2;

   modport master (output start, chan, PK0, SIGPK, TR, input busy, done, A1, A2);
   modport slave  (input start, chan, PK0, SIGPK, TR, output busy, done, A1, A2);
endinterface

// File: rtl/pole_adapt.sv
// Multi-channel G.726 second-order pole coefficient adaptation (UPA2, LIMC,
// UPA1, LIMD, TR reset) run as a fixed six-cycle schedule per request.
module pole_adapt #(
   parameter int NCH = 32,
   parameter int CW  = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic scan_in0,
   input  logic scan_in1,
   input  logic scan_in2,
   input  logic scan_in3,
   input  logic scan_in4,
   input  logic scan_enable,
   input  logic test_mode,
   output logic scan_out0,
   output logic scan_out1,
   output logic scan_out2,
   output logic scan_out3,
   output logic scan_out4,
   pole_adapt_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_UPA2, S_LIMC, S_UPA1, S_LIMD, S_STORE
   } state_t;

   function automatic logic [15:0] upa2(input logic [15:0] a1, input logic [15:0] a2,
                                        input logic pks1, input logic pks2,
                                        input logic sigpk);
      logic [16:0] uga2a, a1x, sh, fa1, fa, uga2b;
      logic [15:0] uga2, ula2;
      uga2a = pks2 ? 17'd114688 : 17'd16384;
      a1x   = {1'b0, a1};
      sh    = a1x << 2;
      if (!a1[15]) fa1 = (a1 <= 16'd8191)  ? sh : 17'd32764;
      else         fa1 = (a1 >= 16'd57345) ? sh : 17'd98308;
      fa    = pks1 ? fa1 : 17'd0 - fa1;
      uga2b = uga2a + fa;
      uga2  = sigpk ? 16'd0 : 16'(uga2b >> 7) + (uga2b[16] ? 16'd64512 : 16'd0);
      ula2  = a2[15] ? 16'd0 - ((a2 >> 7) + 16'd65024) : 16'd0 - (a2 >> 7);
      return a2 + uga2 + ula2;
   endfunction

   function automatic logic [15:0] lim_c(input logic [15:0] a2t);
      if (a2t >= 16'd32768 && a2t <= 16'd53248)      return 16'd53248;
      else if (a2t >= 16'd12288 && a2t <= 16'd32767) return 16'd12288;
      else                                           return a2t;
   endfunction

   function automatic logic [15:0] upa1(input logic [15:0] a1, input logic pks1,
                                        input logic sigpk);
      logic [15:0] uga1, ula1;
      uga1 = sigpk ? 16'd0 : (pks1 ? 16'd65344 : 16'd192);
      ula1 = a1[15] ? 16'd0 - ((a1 >> 8) + 16'd65280) : 16'd0 - (a1 >> 8);
      return a1 + uga1 + ula1;
   endfunction

   function automatic logic [15:0] lim_d(input logic [15:0] a1t, input logic [15:0] a2p);
      logic [15:0] a1ul, a1ll;
      a1ul = 16'd15360 - a2p;
      a1ll = a2p - 16'd15360;
      if (a1t >= 16'd32768 && a1t <= a1ll)     return a1ll;
      else if (a1t >= a1ul && a1t <= 16'd32767) return a1ul;
      else                                     return a1t;
   endfunction

   state_t        state_q, state_d;
   logic [15:0]   mem_a1_q [NCH];
   logic [15:0]   mem_a2_q [NCH];
   logic [NCH-1:0] mem_pk1_q, mem_pk2_q;
   logic [15:0]   a1o_q, a1o_d, a2o_q, a2o_d;
   logic [CW-1:0] chan_q, chan_d;
   logic          pk0_q, pk0_d, sig_q, sig_d, tr_q, tr_d;
   logic          pk1_q, pk1_d, pk2_q, pk2_d;
   logic [15:0]   a1_q, a1_d, a2_q, a2_d, a1p_q, a1p_d, a2p_q, a2p_d;
   logic          mem_we;
   logic          pks1, pks2;

   assign pks1 = pk0_q ^ pk1_q;
   assign pks2 = pk0_q ^ pk2_q;

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      pk0_d   = pk0_q;
      sig_d   = sig_q;
      tr_d    = tr_q;
      pk1_d   = pk1_q;
      pk2_d   = pk2_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      a1p_d   = a1p_q;
      a2p_d   = a2p_q;
      a1o_d   = a1o_q;
      a2o_d   = a2o_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LOAD;
               chan_d  = bus.chan;
               pk0_d   = bus.PK0;
               sig_d   = bus.SIGPK;
               tr_d    = bus.TR;
            end
         end
         S_LOAD: begin
            a1_d    = mem_a1_q[chan_q];
            a2_d    = mem_a2_q[chan_q];
            pk1_d   = mem_pk1_q[chan_q];
            pk2_d   = mem_pk2_q[chan_q];
            state_d = S_UPA2;
         end
         S_UPA2: begin
            a2p_d   = upa2(a1_q, a2_q, pks1, pks2, sig_q);
            state_d = S_LIMC;
         end
         S_LIMC: begin
            a2p_d   = lim_c(a2p_q);
            state_d = S_UPA1;
         end
         S_UPA1: begin
            a1p_d   = upa1(a1_q, pks1, sig_q);
            state_d = S_LIMD;
         end
         // Results land in the output registers here so they are valid during STORE/done
         S_LIMD: begin
            a1o_d   = tr_q ? 16'd0 : lim_d(a1p_q, a2p_q);
            a2o_d   = tr_q ? 16'd0 : a2p_q;
            state_d = S_STORE;
         end
         S_STORE: begin
            mem_we  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control, outputs and channel storage: cleared by reset; reset also blocks write-back
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a1o_q     <= 16'd0;
         a2o_q     <= 16'd0;
         mem_pk1_q <= '0;
         mem_pk2_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            mem_a1_q[i] <= 16'd0;
            mem_a2_q[i] <= 16'd0;
         end
      end else begin
         state_q <= state_d;
         a1o_q   <= a1o_d;
         a2o_q   <= a2o_d;
         if (mem_we) begin
            mem_a1_q[chan_q]  <= a1o_q;
            mem_a2_q[chan_q]  <= a2o_q;
            mem_pk1_q[chan_q] <= pk0_q;
            mem_pk2_q[chan_q] <= pk1_q;
         end
      end
   end

   // Working registers only matter between LOAD and STORE, so they carry no reset
   always_ff @(posedge clk) begin
      chan_q <= chan_d;
      pk0_q  <= pk0_d;
      sig_q  <= sig_d;
      tr_q   <= tr_d;
      pk1_q  <= pk1_d;
      pk2_q  <= pk2_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      a1p_q  <= a1p_d;
      a2p_q  <= a2p_d;
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = (state_q == S_STORE);
   assign bus.A1   = a1o_q;
   assign bus.A2   = a2o_q;

   assign scan_out0 = test_mode & scan_enable & scan_in0;
   assign scan_out1 = test_mode & scan_enable & scan_in1;
   assign scan_out2 = test_mode & scan_enable & scan_in2;
   assign scan_out3 = test_mode & scan_enable & scan_in3;
   assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule

// File: tb/tb_pole_adapt.sv
// Bench for pole_adapt: integer reference model of the G.726 pole update with
// per-cycle comparison, plus literal expectations from hand-worked cases.
module tb_pole_adapt;
   localparam int NCH = 32;
   localparam int CW  = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scan_in0 = 1'b0, scan_in1 = 1'b0, scan_in2 = 1'b0, scan_in3 = 1'b0, scan_in4 = 1'b0;
   logic scan_enable = 1'b0, test_mode = 1'b0;
   logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

   pole_adapt_if #(.CW(CW)) bus ();

   pole_adapt #(.NCH(NCH), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
      .scan_in3(scan_in3), .scan_in4(scan_in4),
      .scan_enable(scan_enable), .test_mode(test_mode),
      .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
      .scan_out3(scan_out3), .scan_out4(scan_out4),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Reference model: channel state as plain integers
   int md_a1 [NCH];
   int md_a2 [NCH];
   int md_pk1 [NCH];
   int md_pk2 [NCH];
   int cnt = 0;
   int c_ch, c_pk0, c_sig, c_tr;
   int exp_a1 = 0, exp_a2 = 0, exp_busy = 0, exp_done = 0;
   bit chk_en = 1'b0;

   task automatic model_update();
      int a1, a2, pks1, pks2, uga2a, fa1, fa, uga2b, uga2, ula2, a2t, a2p;
      int uga1, ula1, a1t, a1ul, a1ll, a1p;
      a1 = md_a1[c_ch];
      a2 = md_a2[c_ch];
      pks1 = c_pk0 ^ md_pk1[c_ch];
      pks2 = c_pk0 ^ md_pk2[c_ch];
      uga2a = pks2 ? 114688 : 16384;
      if (a1 < 32768) fa1 = (a1 <= 8191) ? a1 * 4 : 32764;
      else            fa1 = (a1 >= 57345) ? (a1 * 4) % 131072 : 98308;
      fa = pks1 ? fa1 : (131072 - fa1) % 131072;
      uga2b = (uga2a + fa) % 131072;
      uga2 = c_sig ? 0 : uga2b / 128 + ((uga2b >= 65536) ? 64512 : 0);
      ula2 = (a2 < 32768) ? (65536 - a2 / 128) % 65536 : (65536 - (a2 / 128 + 65024)) % 65536;
      a2t = (a2 + (uga2 + ula2) % 65536) % 65536;
      if (a2t >= 32768 && a2t <= 53248)      a2p = 53248;
      else if (a2t >= 12288 && a2t <= 32767) a2p = 12288;
      else                                   a2p = a2t;
      uga1 = c_sig ? 0 : (pks1 ? 65344 : 192);
      ula1 = (a1 < 32768) ? (65536 - a1 / 256) % 65536 : (65536 - (a1 / 256 + 65280)) % 65536;
      a1t = (a1 + (uga1 + ula1) % 65536) % 65536;
      a1ul = (15360 + 65536 - a2p) % 65536;
      a1ll = (a2p + 65536 - 15360) % 65536;
      if (a1t >= 32768 && a1t <= a1ll)     a1p = a1ll;
      else if (a1t >= a1ul && a1t <= 32767) a1p = a1ul;
      else                                 a1p = a1t;
      if (c_tr != 0) begin
         a1p = 0;
         a2p = 0;
      end
      md_a1[c_ch]  = a1p;
      md_a2[c_ch]  = a2p;
      md_pk2[c_ch] = md_pk1[c_ch];
      md_pk1[c_ch] = c_pk0;
      exp_a1 = a1p;
      exp_a2 = a2p;
   endtask

   // cnt = cycles remaining until the request completes (6 right after acceptance)
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            md_a1[i] = 0; md_a2[i] = 0; md_pk1[i] = 0; md_pk2[i] = 0;
         end
         cnt = 0; exp_a1 = 0; exp_a2 = 0;
         chk_en = 1'b1;
      end else if (cnt == 0) begin
         if (bus.start) begin
            c_ch = int'(bus.chan); c_pk0 = int'(bus.PK0);
            c_sig = int'(bus.SIGPK); c_tr = int'(bus.TR);
            cnt = 6;
         end
      end else begin
         cnt--;
         if (cnt == 1) model_update();
      end
      exp_busy = (cnt != 0) ? 1 : 0;
      exp_done = (cnt == 1) ? 1 : 0;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", int'(bus.busy), exp_busy);
         chk("done", int'(bus.done), exp_done);
         chk("A1", int'(bus.A1), exp_a1);
         chk("A2", int'(bus.A2), exp_a2);
         chk("scan_out_mask", int'({scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}),
             test_mode ? int'({scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} & {5{scan_enable}}) : 0);
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_A1", int'(bus.A1), 0);
      chk("rst_A2", int'(bus.A2), 0);
   endtask

   // One request; e1 < 0 means rely on the per-cycle model check only
   task automatic run_update(input int ch, input int pk0, input int sig, input int tr,
                             input int e1, input int e2, input string nm);
      int k;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.chan = CW'(ch); bus.PK0 = pk0[0]; bus.SIGPK = sig[0]; bus.TR = tr[0];
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.chan = CW'($urandom); bus.PK0 = ~bus.PK0; bus.SIGPK = ~bus.SIGPK; bus.TR = ~bus.TR;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      chk({nm, "_latency"}, k, 6);
      if (e1 >= 0) begin
         chk({nm, "_A1"}, int'(bus.A1), e1);
         chk({nm, "_A2"}, int'(bus.A2), e2);
      end
   endtask

   // Drive start in the listed cycles and optionally reset; count done pulses
   task automatic pulse_seq(input int s0, input int s1, input int rcyc,
                            output int ndone, output int dpos);
      ndone = 0; dpos = -1;
      @(posedge clk); #1;
      for (int k = 0; k < 12; k++) begin
         bus.start = (k == s0 || k == s1);
         bus.chan = '0; bus.PK0 = 1'b0; bus.SIGPK = 1'b0; bus.TR = 1'b0;
         reset = (k == rcyc);
         @(negedge clk);
         if (bus.done) begin ndone++; dpos = k; end
         @(posedge clk); #1;
      end
      bus.start = 1'b0; reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int nd, dp;
      bus.start = 1'b0; bus.chan = '0; bus.PK0 = 1'b0; bus.SIGPK = 1'b0; bus.TR = 1'b0;
      do_reset();

      run_update(0, 0, 0, 0, 192, 128, "c0_first");
      run_update(0, 0, 0, 0, 384, 249, "c0_second");

      do_reset();
      run_update(5, 0, 1, 0, 0, 0, "c5_sigpk");
      run_update(5, 0, 0, 0, 192, 128, "c5_normal");

      run_update(3, 0, 0, 0, 192, 128, "c3_first");
      run_update(3, 0, 0, 0, 384, 249, "c3_second");
      run_update(4, 0, 1, 0, 0, 0, "c4_isolation");
      run_update(3, 0, 0, 0, 575, 364, "c3_third");

      run_update(0, 0, 0, 0, 192, 128, "c0_pre_tr1");
      run_update(0, 0, 0, 0, 384, 249, "c0_pre_tr2");
      run_update(0, 0, 0, 1, 0, 0, "c0_tr");
      run_update(0, 0, 0, 0, 192, 128, "c0_after_tr");

      do_reset();
      pulse_seq(0, 3, -1, nd, dp);
      chk("busy_start_ignored_count", nd, 1);
      chk("busy_start_done_pos", dp, 6);
      pulse_seq(0, 0, 4, nd, dp);
      chk("reset_abort_done_count", nd, 0);
      run_update(0, 0, 0, 0, 192, 128, "c0_after_abort");

      test_mode = 1'b1; scan_enable = 1'b1;
      {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b10110;
      @(negedge clk);
      test_mode = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 150; i++) run_update(1, 0, 0, 0, -1, -1, "drift_pos");
      for (int i = 0; i < 150; i++) run_update(2, i % 2, 0, 0, -1, -1, "drift_neg");
      for (int i = 0; i < 150; i++) run_update(6, (i / 2) % 2, 0, 0, -1, -1, "drift_a2");

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         bus.start = (($urandom % 3) == 0);
         bus.chan  = CW'($urandom % 8);
         bus.PK0   = 1'($urandom);
         bus.SIGPK = (($urandom % 5) == 0);
         bus.TR    = (($urandom % 20) == 0);
         reset     = (($urandom % 400) == 0);
      end
      @(posedge clk); #1;
      bus.start = 1'b0; reset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
